// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, FSM states, round constants and byte-level helpers.
package aes_pkg;
   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;
   typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;
   localparam int NR = 10;
   // Indexed by the round whose key is being produced; entry 0 and 11..15 never used.
   localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   function automatic byte_t xtime(byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
   function automatic block_t shift_rows(block_t b);
      block_t r;
      for (int c = 0; c < 4; c++)
         for (int q = 0; q < 4; q++)
            r[127-8*(4*c+q) -: 8] = b[127-8*(4*((c+q)%4)+q) -: 8];
      return r;
   endfunction
endpackage

// File: rtl/aes_if.sv
// aes_if: request/result bundle between an AES client (master) and the encryptor (slave).
interface aes_if;
   import aes_pkg::*;
   logic   AES_START;
   block_t AES_KEY;
   block_t AES_MSG_DEC;
   block_t AES_MSG_ENC;
   logic   AES_DONE;
   modport master (output AES_START, AES_KEY, AES_MSG_DEC, input AES_MSG_ENC, AES_DONE);
   modport slave (input AES_START, AES_KEY, AES_MSG_DEC, output AES_MSG_ENC, AES_DONE);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational FIPS-197 S-box lookup.
module aes_sbox
   import aes_pkg::*;
(
   input  byte_t a,
   output byte_t y
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16};
   assign y = SBOX[a];
endmodule

// File: rtl/aes_encrypt.sv
// aes_encrypt: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
module aes_encrypt
   import aes_pkg::*;
(
   input logic CLK,
   input logic RESET,
   aes_if.slave bus
);
   state_t     st;
   logic [3:0] cnt;
   block_t     s, k, sb, sr, mc, nk;
   word_t      ks, t;
   logic [3:0] rn;
   function automatic block_t mix_columns(block_t b);
      block_t r;
      byte_t a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = b[127-32*c -: 32];
         r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return r;
   endfunction
   for (genvar i = 0; i < 16; i++) begin : g_sb
      aes_sbox u_sb (.a(s[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
   end
   // Key schedule only ever substitutes the last word of the current round key.
   for (genvar j = 0; j < 4; j++) begin : g_ks
      aes_sbox u_ks (.a(k[31-8*j -: 8]), .y(ks[31-8*j -: 8]));
   end
   always_comb begin
      sr = shift_rows(sb);
      mc = mix_columns(sr);
      rn = cnt + 4'd1;
      t  = {ks[23:0], ks[31:24]} ^ {RCON[rn], 24'h0};
      nk[127:96] = k[127:96] ^ t;
      nk[95:64]  = k[95:64] ^ nk[127:96];
      nk[63:32]  = k[63:32] ^ nk[95:64];
      nk[31:0]   = k[31:0] ^ nk[63:32];
   end
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         st              <= IDLE;
         cnt             <= '0;
         s               <= '0;
         k               <= '0;
         bus.AES_MSG_ENC <= '0;
         bus.AES_DONE    <= 1'b0;
      end else
         case (st)
            IDLE:
               if (bus.AES_START) begin
                  s  <= bus.AES_MSG_DEC;
                  k  <= bus.AES_KEY;
                  st <= INIT;
               end
            INIT: begin
               s   <= s ^ k;
               k   <= nk;
               cnt <= 4'd1;
               st  <= ROUND;
            end
            ROUND: begin
               s   <= mc ^ k;
               k   <= nk;
               cnt <= cnt + 4'd1;
               st  <= (cnt == 4'(NR - 1)) ? FINAL : ROUND;
            end
            FINAL: begin
               bus.AES_MSG_ENC <= sr ^ k;
               st              <= DONE;
            end
            // DONE is held at least one cycle with AES_DONE high before start is re-examined.
            DONE:
               if (!bus.AES_DONE) bus.AES_DONE <= 1'b1;
               else if (!bus.AES_START) begin
                  bus.AES_DONE <= 1'b0;
                  cnt          <= '0;
                  st           <= IDLE;
               end
            default: st <= IDLE;
         endcase
endmodule

// File: tb/tb_aes_encrypt.sv
// tb_aes_encrypt: known-answer, protocol and randomized checks against a byte-array AES model.
module tb_aes_encrypt;
   typedef logic [0:15][7:0]  st_t;
   typedef logic [0:175][7:0] rk_t;
   logic CLK = 1'b0, RESET = 1'b0;
   logic [7:0] sb [256], isb [256];
   int checks = 0, errors = 0;
   aes_if bus();
   aes_encrypt dut (.CLK(CLK), .RESET(RESET), .bus(bus));
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] x = a, y = b, p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction
   // S-box built from its definition: multiplicative inverse followed by the affine map.
   task automatic build_tables();
      logic [7:0] inv, v;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         v = 8'h63;
         for (int q = 0; q < 8; q++)
            v[q] = v[q] ^ inv[q] ^ inv[(q+4)%8] ^ inv[(q+5)%8] ^ inv[(q+6)%8] ^ inv[(q+7)%8];
         sb[x]  = v;
         isb[v] = 8'(x);
      end
   endtask
   function automatic rk_t expand(logic [127:0] key);
      rk_t rk;
      logic [7:0] t [4];
      logic [7:0] rc = 8'h01, tmp;
      rk[0:15] = key;
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) t[j] = rk[4*(i-1)+j];
         if (i % 4 == 0) begin
            tmp  = t[0];
            t[0] = sb[t[1]] ^ rc;
            t[1] = sb[t[2]];
            t[2] = sb[t[3]];
            t[3] = sb[tmp];
            rc   = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) rk[4*i+j] = rk[4*(i-4)+j] ^ t[j];
      end
      return rk;
   endfunction
   function automatic logic [127:0] aes_ref(logic [127:0] key, logic [127:0] pt);
      rk_t rk = expand(key);
      st_t s = pt, t;
      for (int i = 0; i < 16; i++) s[i] ^= rk[i];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         t = s;
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
         if (rnd < 10) begin
            t = s;
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] ^= rk[16*rnd+i];
      end
      return s;
   endfunction
   function automatic logic [127:0] aes_dec(logic [127:0] key, logic [127:0] ct);
      rk_t rk = expand(key);
      st_t s = ct, t;
      for (int i = 0; i < 16; i++) s[i] ^= rk[160+i];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         t = s;
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r+4*((c+r)%4)] = t[r+4*c];
         for (int i = 0; i < 16; i++) s[i] = isb[s[i]] ^ rk[16*rnd+i];
         if (rnd > 0) begin
            t = s;
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
               s[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
               s[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
               s[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
            end
         end
      end
      return s;
   endfunction
   task automatic start_run(input logic [127:0] key, input logic [127:0] pt);
      @(negedge CLK);
      bus.AES_KEY     = key;
      bus.AES_MSG_DEC = pt;
      bus.AES_START   = 1'b1;
   endtask
   // lat = edges after the sampling edge; drop/chg act after that many edges (0 = never).
   task automatic wait_done(input int drop, input int chg, output int lat);
      logic [127:0] prev = bus.AES_MSG_ENC;
      bit stable = 1'b1;
      int n = 0;
      do begin
         @(posedge CLK);
         #1;
         n++;
         if (n < 12 && bus.AES_MSG_ENC !== prev) stable = 1'b0;
         if (n == drop) bus.AES_START = 1'b0;
         if (n == chg) begin
            bus.AES_KEY     = '1;
            bus.AES_MSG_DEC = '1;
         end
      end while (!bus.AES_DONE && n < 40);
      lat = n - 1;
      check("enc_hold_in_run", 128'(stable), 128'd1);
   endtask
   task automatic end_run();
      @(negedge CLK);
      bus.AES_START = 1'b0;
      @(posedge CLK);
      #1;
      check("done_clear", 128'(bus.AES_DONE), 128'd0);
   endtask
   initial begin
      logic [127:0] k1 = 128'h000102030405060708090a0b0c0d0e0f;
      logic [127:0] p1 = 128'h00112233445566778899aabbccddeeff;
      logic [127:0] c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      logic [127:0] k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      logic [127:0] p2 = 128'h3243f6a8885a308d313198a2e0370734;
      logic [127:0] c2 = 128'h3925841d02dc09fbdc118597196a0b32;
      logic [127:0] kr, pr;
      int lat;
      bit ok;
      bus.AES_START = 1'b0;
      bus.AES_KEY = '0;
      bus.AES_MSG_DEC = '0;
      build_tables();
      repeat (3) @(posedge CLK);
      #1;
      check("rst_done", 128'(bus.AES_DONE), 128'd0);
      check("rst_enc", bus.AES_MSG_ENC, 128'd0);
      @(negedge CLK) RESET = 1'b1;
      start_run(k1, p1);
      wait_done(0, 0, lat);
      check("lat_kat1", 128'(lat), 128'd12);
      check("kat1", bus.AES_MSG_ENC, c1);
      check("ref_kat1", bus.AES_MSG_ENC, aes_ref(k1, p1));
      ok = 1'b1;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (!bus.AES_DONE || bus.AES_MSG_ENC !== c1) ok = 1'b0;
      end
      check("start_held", 128'(ok), 128'd1);
      end_run();
      check("enc_after_idle", bus.AES_MSG_ENC, c1);
      start_run(k2, p2);
      wait_done(0, 0, lat);
      check("lat_kat2", 128'(lat), 128'd12);
      check("kat2", bus.AES_MSG_ENC, c2);
      check("loopback", aes_dec(k2, bus.AES_MSG_ENC), p2);
      end_run();
      start_run(k1, p1);
      wait_done(0, 2, lat);
      check("lat_inchg", 128'(lat), 128'd12);
      check("input_change", bus.AES_MSG_ENC, c1);
      end_run();
      start_run(k2, p2);
      wait_done(1, 0, lat);
      check("lat_drop", 128'(lat), 128'd12);
      check("early_drop", bus.AES_MSG_ENC, c2);
      @(posedge CLK);
      #1;
      check("drop_exit", 128'(bus.AES_DONE), 128'd0);
      start_run(k1, p1);
      repeat (5) @(posedge CLK);
      #2 RESET = 1'b0;
      #1;
      check("abort_done", 128'(bus.AES_DONE), 128'd0);
      check("abort_enc", bus.AES_MSG_ENC, 128'd0);
      @(negedge CLK) bus.AES_START = 1'b0;
      @(negedge CLK) RESET = 1'b1;
      start_run(k2, p2);
      wait_done(0, 0, lat);
      check("lat_rerun", 128'(lat), 128'd12);
      check("rerun", bus.AES_MSG_ENC, c2);
      end_run();
      repeat (20) begin
         kr = {$urandom, $urandom, $urandom, $urandom};
         pr = {$urandom, $urandom, $urandom, $urandom};
         start_run(kr, pr);
         wait_done(0, 0, lat);
         check("lat_rand", 128'(lat), 128'd12);
         check("rand", bus.AES_MSG_ENC, aes_ref(kr, pr));
         end_run();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_encrypt.md
AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 SHALL provide: CLK  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL provide: RESET  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: AES_START  in  1  level request; rising-edge sampled while idle.
REQ-004 SHALL provide: AES_KEY  in  128  cipher key, byte 0 = bits [127:120].
REQ-005 SHALL provide: AES_MSG_DEC  in  128  plaintext block, same byte order.
REQ-006 SHALL provide: AES_MSG_ENC  out  128  ciphertext block, registered.
REQ-007 SHALL provide: AES_DONE  out  1  ciphertext valid / handshake complete.
REQ-008 SHALL fix parameter NR = 10 (AES-128 only); no other parameters.

Function
REQ-009 SHALL implement FIPS-197 AES-128 encryption, bit-exact.
REQ-010 SHALL use FSM states IDLE, INIT, ROUND, FINAL, DONE.
REQ-011 IDLE: AES_START=1 at clock edge -> capture AES_KEY and AES_MSG_DEC into internal state/key registers -> INIT.
REQ-012 INIT (1 cycle): state ^= key (round 0); round key <- expansion round 1; round counter <- 1 -> ROUND.
REQ-013 ROUND (9 cycles, counter 1..9): SubBytes, ShiftRows, MixColumns, AddRoundKey with current round key; round key advances one expansion step per cycle; counter==9 -> FINAL.
REQ-014 FINAL (1 cycle): SubBytes, ShiftRows, AddRoundKey (no MixColumns); result written to AES_MSG_ENC -> DONE.
REQ-015 Latency: AES_DONE rises exactly 12 clock edges after the edge sampling AES_START in IDLE (1 INIT + 9 ROUND + 1 FINAL + 1 DONE-entry edge).
REQ-016 Key expansion on the fly: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ Rcon for first word, chained XOR for remaining three; Rcon sequence 01,02,04,08,10,20,40,80,1b,36.
REQ-017 MixColumns multiplication in GF(2^8) with reduction polynomial 0x11b (xtime: shift left, XOR 0x1b on carry-out).
REQ-018 DONE: AES_DONE=1; remain while AES_START=1; AES_START=0 -> IDLE with AES_DONE=0 next cycle.
REQ-019 AES_START held high through DONE SHALL NOT start a new encryption; a new run requires AES_START low for at least one cycle in DONE/IDLE.
REQ-020 AES_START deasserted during INIT/ROUND/FINAL SHALL be ignored; computation completes, DONE entered, then exits next cycle if AES_START still 0.
REQ-021 AES_KEY/AES_MSG_DEC changes after capture SHALL NOT affect the in-flight result.
REQ-022 AES_MSG_ENC SHALL change only on the FINAL->DONE edge and hold its value otherwise, including across IDLE.
REQ-023 AES_DONE SHALL be a registered FSM decode (no combinational path from inputs).

Reset
REQ-024 RESET=0 SHALL immediately force state IDLE, AES_DONE=0, AES_MSG_ENC=0, counter=0, internal state/key registers=0.
REQ-025 RESET asserted mid-operation SHALL abort the run; no partial ciphertext SHALL appear on AES_MSG_ENC.
REQ-026 After RESET release, the first AES_START=1 edge SHALL start a run normally.

Structure
REQ-027 Shared package aes_pkg SHALL hold: FSM state enum, NR, Rcon table, byte/word/block typedefs, xtime and ShiftRows helper functions.
REQ-028 One sub-module aes_sbox (8-bit in, 8-bit out, combinational ROM) SHALL be instantiated 20 times (16 datapath, 4 key schedule).
REQ-029 Top module SHALL contain FSM, round counter, state/key registers, MixColumns and AddRoundKey logic only.

Verification
REQ-030 Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> AES_MSG_ENC=69c4e0d86a7b0430d8cdb78070b4c55a, AES_DONE 12 edges after START.
REQ-031 Key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-032 START held high 40 cycles after vector REQ-030 -> AES_DONE stays 1, single run only; START low -> AES_DONE 0 next cycle; AES_MSG_ENC unchanged.
REQ-033 RESET=0 at cycle 5 of a run -> AES_DONE=0, AES_MSG_ENC=0 immediately; re-run with REQ-031 vector -> correct ciphertext.
REQ-034 Change AES_KEY/AES_MSG_DEC to all-ones 2 cycles after START of REQ-030 vector -> output still 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-035 Loopback: ciphertext from REQ-031 fed to existing AES decryptor with same key -> 3243f6a8885a308d313198a2e0370734.
